writeback_buffer: RTL and testbench
===================================

Name: writeback_buffer

Overview:
- In-order FIFO of pending register writes. It sits directly upstream of the register file and drives its single write port (WEN/wsel/wdat).
- Absorbs results while the write port is owned by another writer (port_busy), then drains one entry per free cycle, oldest first.
- Provides two forwarding lookups so decode reads see values still queued here and not yet in the register file.

Parameters:
- DEPTH, 4, number of buffered write entries (power of 2, ≥2).

Ports:
- CLK  in  1  clock
- nRST  in  1  async active-low reset
- enq_valid  in  1  producer has a result to write
- enq_wsel  in  5  destination register
- enq_wdat  in  32  result word
- enq_ready  out  1  buffer accepts this cycle
- port_busy  in  1  register-file write port owned by another writer this cycle
- WEN  out  1  register-file write enable
- wsel  out  5  register-file write select
- wdat  out  32  register-file write data
- rsel1  in  5  decode read select 1
- rsel2  in  5  decode read select 2
- fwd1_hit  out  1  rsel1 matches a buffered entry
- fwd1_dat  out  32  youngest matching data for rsel1
- fwd2_hit  out  1  rsel2 matches a buffered entry
- fwd2_dat  out  32  youngest matching data for rsel2
- count  out  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Reset: nRST is asynchronous, active-low; clock is CLK. Reset clears head/tail pointers, count=0 and all entry valid bits.
  - With count=0: WEN=0, wsel=0, wdat=0, fwd*_hit=0, fwd*_dat=0.
- Enqueue: a handshake occurs when enq_valid && enq_ready at the rising edge. The entry is written at the tail and tail advances, modulo DEPTH.
- Register 0: enq_wsel==0 is accepted (consumes the handshake) but not stored. count is unchanged.
- Drain (combinational from the head entry):
  - WEN = (count!=0) && !port_busy.
  - wsel/wdat = head entry when WEN, else 0.
  - On an edge with WEN=1, head advances.
- enq_ready = (count<DEPTH) || WEN. When full, an accept is allowed in the same cycle as a pop.
- count next-state:
  - +1 on a stored enqueue without a pop.
  - −1 on a pop without a stored enqueue.
  - Unchanged otherwise, including when both occur in the same cycle.
- Latency: minimum 1 cycle. An entry enqueued at edge N can produce WEN in cycle N+1 at the earliest; there is no same-cycle pass-through.
- Forwarding: combinational search over valid entries, youngest to oldest.
  - The first entry with wsel==rselX sets fwdX_hit=1 and fwdX_dat to that entry's data.
  - rselX==0 never hits.
  - The head entry being drained this cycle still hits, because the register file is updated only at the edge.
  - An enqueue in the current cycle is not visible until the next cycle.
- Ordering: multiple entries to the same register drain in program order, so the register file ends with the youngest value.
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally. Full/empty are decided by count, not by pointer equality.
- port_busy held high indefinitely: the buffer fills, enq_ready drops, no entry is lost, and forwarding stays valid.
- Reset mid-operation: all buffered entries are discarded and no WEN is issued after nRST falls.

Decomposition:
- cpu_types_pkg supplies word_t (32-bit) and regbits_t (5-bit). Entry struct wb_entry_t {regbits_t wsel; word_t wdat;} is added to the package.
- Youngest-match search is a function inside this module. No sub-module.

Test Plan:
- Reset, then port_busy=0; enqueue (r5,0xDEADBEEF) -> next cycle WEN=1, wsel=5, wdat=0xDEADBEEF; following cycle count=0, WEN=0.
- port_busy=1; enqueue r1..r4 = 0x11,0x22,0x33,0x44 -> count=4, enq_ready=0, WEN=0. Release port_busy -> four consecutive writes in order r1..r4, enq_ready=1 in the first release cycle.
- Full with port_busy=0 and enq_valid for (r7,0x77) -> pop r1 and accept r7 in the same edge; count stays 4; r7 drains fifth.
- port_busy=1; enqueue (r3,0xA) then (r3,0xB); rsel1=3 -> fwd1_hit=1, fwd1_dat=0xB. Drain -> register-file writes 0xA then 0xB.
- enqueue wsel=0 data 0xFFFF -> enq_ready=1, count unchanged, no WEN. rsel1=0 -> fwd1_hit=0.
- port_busy=1, 3 entries queued; assert nRST=0 mid-cycle -> count=0, WEN=0 immediately. After release, nothing drains.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// ---------------------------------------------------------------------------
// cpu_types_pkg
// Shared CPU datapath types.
//   word_t      : 32-bit architectural data word
//   regbits_t   : 5-bit register index (r0 is hard-wired zero)
//   wb_entry_t  : one pending register write held by writeback_buffer
// ---------------------------------------------------------------------------
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    typedef struct packed {
        regbits_t wsel;
        word_t    wdat;
    } wb_entry_t;

endpackage

// File: rtl/writeback_buffer.sv
// ---------------------------------------------------------------------------
// writeback_buffer
// In-order queue of pending register writes sitting in front of the register
// file write port. Results are absorbed while another writer owns the port
// (port_busy) and drained oldest-first, one per free cycle. Two combinational
// lookups expose still-queued values to decode.
//
// Ports
//   CLK, nRST              : clock, asynchronous active-low reset
//   enq_valid/wsel/wdat    : producer write request
//   enq_ready              : request accepted at the next rising edge
//   port_busy              : write port taken by another writer this cycle
//   WEN/wsel/wdat          : register file write port
//   rsel1/rsel2            : decode read selects
//   fwd1_hit/fwd1_dat      : youngest queued value for rsel1
//   fwd2_hit/fwd2_dat      : youngest queued value for rsel2
//   count                  : current occupancy
// ---------------------------------------------------------------------------
module writeback_buffer
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         CLK,
    input  logic                         nRST,
    input  logic                         enq_valid,
    input  logic [4:0]                   enq_wsel,
    input  logic [31:0]                  enq_wdat,
    output logic                         enq_ready,
    input  logic                         port_busy,
    output logic                         WEN,
    output logic [4:0]                   wsel,
    output logic [31:0]                  wdat,
    input  logic [4:0]                   rsel1,
    input  logic [4:0]                   rsel2,
    output logic                         fwd1_hit,
    output logic [31:0]                  fwd1_dat,
    output logic                         fwd2_hit,
    output logic [31:0]                  fwd2_dat,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int CW   = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    wb_entry_t        r_entries [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [PTRW-1:0]  r_head;
    logic [PTRW-1:0]  r_tail;
    logic [CW-1:0]    r_count;

    logic             w_pop;
    logic             w_ready;
    logic             w_push;
    logic [32:0]      w_fwd1;
    logic [32:0]      w_fwd2;

    // Full/empty come from the occupancy counter; pointers alone are
    // ambiguous when head == tail. A full buffer still accepts when the
    // head leaves in the same cycle. Writes to r0 complete the handshake
    // but are dropped since r0 never changes.
    assign w_pop   = (r_count != '0) && !port_busy;
    assign w_ready = (r_count != FULL_COUNT) || w_pop;
    assign w_push  = enq_valid && w_ready && (enq_wsel != '0);

    // Walk oldest to youngest so the last match found is the youngest.
    function automatic logic [32:0] findYoungest(input regbits_t sel);
        logic [32:0]     res;
        logic [PTRW-1:0] idx;
        res = '0;
        if (sel != '0) begin
            for (int k = 0; k < DEPTH; k++) begin
                idx = r_head + PTRW'(k);
                if (r_valid[idx] && (r_entries[idx].wsel == sel)) begin
                    res = {1'b1, r_entries[idx].wdat};
                end
            end
        end
        return res;
    endfunction

    // Pointer, valid-bit and occupancy state. When full with a simultaneous
    // pop and push, head and tail name the same slot; the push is written
    // last so the slot ends up valid with the new entry.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
            if (w_push) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry payload needs no reset; the valid bits gate every use of it.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_entries[r_tail] <= '{wsel: enq_wsel, wdat: enq_wdat};
        end
    end

    always_comb begin
        w_fwd1   = findYoungest(rsel1);
        w_fwd2   = findYoungest(rsel2);
        WEN      = w_pop;
        wsel     = '0;
        wdat     = '0;
        if (w_pop) begin
            wsel = r_entries[r_head].wsel;
            wdat = r_entries[r_head].wdat;
        end
    end

    assign enq_ready = w_ready;
    assign fwd1_hit  = w_fwd1[32];
    assign fwd1_dat  = w_fwd1[31:0];
    assign fwd2_hit  = w_fwd2[32];
    assign fwd2_dat  = w_fwd2[31:0];
    assign count     = r_count;

endmodule

// File: tb/tb_writeback_buffer.sv
// ---------------------------------------------------------------------------
// tb_writeback_buffer
// Directed bench for writeback_buffer (DEPTH = 4).
// ---------------------------------------------------------------------------
module tb_writeback_buffer;

    logic        CLK;
    logic        nRST;
    logic        enq_valid;
    logic [4:0]  enq_wsel;
    logic [31:0] enq_wdat;
    logic        enq_ready;
    logic        port_busy;
    logic        WEN;
    logic [4:0]  wsel;
    logic [31:0] wdat;
    logic [4:0]  rsel1;
    logic [4:0]  rsel2;
    logic        fwd1_hit;
    logic [31:0] fwd1_dat;
    logic        fwd2_hit;
    logic [31:0] fwd2_dat;
    logic [2:0]  count;

    int checks;
    int failures;

    writeback_buffer #(.DEPTH(4)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .enq_valid (enq_valid),
        .enq_wsel  (enq_wsel),
        .enq_wdat  (enq_wdat),
        .enq_ready (enq_ready),
        .port_busy (port_busy),
        .WEN       (WEN),
        .wsel      (wsel),
        .wdat      (wdat),
        .rsel1     (rsel1),
        .rsel2     (rsel2),
        .fwd1_hit  (fwd1_hit),
        .fwd1_dat  (fwd1_dat),
        .fwd2_hit  (fwd2_hit),
        .fwd2_dat  (fwd2_dat),
        .count     (count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance to just after the next rising edge.
    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [4:0] sel, input logic [31:0] dat);
        enq_valid = 1'b1;
        enq_wsel  = sel;
        enq_wdat  = dat;
        cycle();
        enq_valid = 1'b0;
    endtask

    task automatic test_reset();
        nRST      = 1'b0;
        enq_valid = 1'b0;
        enq_wsel  = '0;
        enq_wdat  = '0;
        port_busy = 1'b0;
        rsel1     = 5'd5;
        rsel2     = 5'd7;
        #2;
        checks++; if (count !== 3'd0) begin failures++; $display("[TB] FAIL reset_count got=%0d exp=0", count); end
        checks++; if (WEN !== 1'b0) begin failures++; $display("[TB] FAIL reset_wen got=%0b exp=0", WEN); end
        checks++; if (wsel !== 5'd0) begin failures++; $display("[TB] FAIL reset_wsel got=%0d exp=0", wsel); end
        checks++; if (wdat !== 32'h0) begin failures++; $display("[TB] FAIL reset_wdat got=%h exp=0", wdat); end
        checks++; if (fwd1_hit !== 1'b0) begin failures++; $display("[TB] FAIL reset_fwd1_hit got=%0b exp=0", fwd1_hit); end
        checks++; if (fwd1_dat !== 32'h0) begin failures++; $display("[TB] FAIL reset_fwd1_dat got=%h exp=0", fwd1_dat); end
        checks++; if (fwd2_hit !== 1'b0) begin failures++; $display("[TB] FAIL reset_fwd2_hit got=%0b exp=0", fwd2_hit); end
        checks++; if (fwd2_dat !== 32'h0) begin failures++; $display("[TB] FAIL reset_fwd2_dat got=%h exp=0", fwd2_dat); end
        checks++; if (enq_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready got=%0b exp=1", enq_ready); end
        cycle();
        cycle();
        nRST = 1'b1;
        cycle();
    endtask

    task automatic test_single();
        port_busy = 1'b0;
        enq_valid = 1'b1;
        enq_wsel  = 5'd5;
        enq_wdat  = 32'hDEADBEEF;
        #1;
        checks++; if (WEN !== 1'b0) begin failures++; $display("[TB] FAIL single_no_passthru got=%0b exp=0", WEN); end
        checks++; if (enq_ready !== 1'b1) begin failures++; $display("[TB] FAIL single_ready got=%0b exp=1", enq_ready); end
        cycle();
        enq_valid = 1'b0;
        #1;
        checks++; if (WEN !== 1'b1) begin failures++; $display("[TB] FAIL single_wen got=%0b exp=1", WEN); end
        checks++; if (wsel !== 5'd5) begin failures++; $display("[TB] FAIL single_wsel got=%0d exp=5", wsel); end
        checks++; if (wdat !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL single_wdat got=%h exp=deadbeef", wdat); end
        checks++; if (count !== 3'd1) begin failures++; $display("[TB] FAIL single_count1 got=%0d exp=1", count); end
        cycle();
        checks++; if (count !== 3'd0) begin failures++; $display("[TB] FAIL single_count0 got=%0d exp=0", count); end
        checks++; if (WEN !== 1'b0) begin failures++; $display("[TB] FAIL single_wen_idle got=%0b exp=0", WEN); end
    endtask

    task automatic test_busy_fill();
        port_busy = 1'b1;
        for (int i = 1; i <= 4; i++) push(5'(i), 32'(i * 17));
        #1;
        checks++; if (count !== 3'd4) begin failures++; $display("[TB] FAIL fill_count got=%0d exp=4", count); end
        checks++; if (enq_ready !== 1'b0) begin failures++; $display("[TB] FAIL fill_ready got=%0b exp=0", enq_ready); end
        checks++; if (WEN !== 1'b0) begin failures++; $display("[TB] FAIL fill_wen got=%0b exp=0", WEN); end
        port_busy = 1'b0;
        #1;
        checks++; if (enq_ready !== 1'b1) begin failures++; $display("[TB] FAIL release_ready got=%0b exp=1", enq_ready); end
        for (int i = 1; i <= 4; i++) begin
            checks++; if (WEN !== 1'b1) begin failures++; $display("[TB] FAIL drain_wen[%0d] got=%0b exp=1", i, WEN); end
            checks++; if (wsel !== 5'(i)) begin failures++; $display("[TB] FAIL drain_wsel[%0d] got=%0d exp=%0d", i, wsel, i); end
            checks++; if (wdat !== 32'(i * 17)) begin failures++; $display("[TB] FAIL drain_wdat[%0d] got=%h exp=%h", i, wdat, 32'(i * 17)); end
            cycle();
        end
        checks++; if (count !== 3'd0) begin failures++; $display("[TB] FAIL drain_count got=%0d exp=0", count); end
        checks++; if (WEN !== 1'b0) begin failures++; $display("[TB] FAIL drain_idle got=%0b exp=0", WEN); end
    endtask

    task automatic test_full_pushpop();
        logic [4:0]  expSel [4];
        logic [31:0] expDat [4];
        expSel = '{5'd2, 5'd3, 5'd4, 5'd7};
        expDat = '{32'h22, 32'h33, 32'h44, 32'h77};
        port_busy = 1'b1;
        for (int i = 1; i <= 4; i++) push(5'(i), 32'(i * 17));
        port_busy = 1'b0;
        enq_valid = 1'b1;
        enq_wsel  = 5'd7;
        enq_wdat  = 32'h77;
        #1;
        checks++; if (enq_ready !== 1'b1) begin failures++; $display("[TB] FAIL full_pop_ready got=%0b exp=1", enq_ready); end
        checks++; if (wsel !== 5'd1) begin failures++; $display("[TB] FAIL full_pop_wsel got=%0d exp=1", wsel); end
        cycle();
        enq_valid = 1'b0;
        #1;
        checks++; if (count !== 3'd4) begin failures++; $display("[TB] FAIL full_pop_count got=%0d exp=4", count); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (WEN !== 1'b1) begin failures++; $display("[TB] FAIL wrap_wen[%0d] got=%0b exp=1", i, WEN); end
            checks++; if (wsel !== expSel[i]) begin failures++; $display("[TB] FAIL wrap_wsel[%0d] got=%0d exp=%0d", i, wsel, expSel[i]); end
            checks++; if (wdat !== expDat[i]) begin failures++; $display("[TB] FAIL wrap_wdat[%0d] got=%h exp=%h", i, wdat, expDat[i]); end
            cycle();
        end
        checks++; if (count !== 3'd0) begin failures++; $display("[TB] FAIL wrap_count got=%0d exp=0", count); end
    endtask

    task automatic test_forward_same_reg();
        port_busy = 1'b1;
        rsel1 = 5'd3;
        rsel2 = 5'd4;
        push(5'd3, 32'hA);
        enq_valid = 1'b1;
        enq_wsel  = 5'd3;
        enq_wdat  = 32'hB;
        #1;
        checks++; if (fwd1_hit !== 1'b1) begin failures++; $display("[TB] FAIL fwd_first_hit got=%0b exp=1", fwd1_hit); end
        checks++; if (fwd1_dat !== 32'hA) begin failures++; $display("[TB] FAIL fwd_not_yet_visible got=%h exp=a", fwd1_dat); end
        cycle();
        enq_valid = 1'b0;
        #1;
        checks++; if (fwd1_dat !== 32'hB) begin failures++; $display("[TB] FAIL fwd_youngest got=%h exp=b", fwd1_dat); end
        checks++; if (fwd2_hit !== 1'b0) begin failures++; $display("[TB] FAIL fwd2_miss got=%0b exp=0", fwd2_hit); end
        checks++; if (count !== 3'd2) begin failures++; $display("[TB] FAIL fwd_count got=%0d exp=2", count); end
        port_busy = 1'b0;
        #1;
        checks++; if (wdat !== 32'hA) begin failures++; $display("[TB] FAIL order_first got=%h exp=a", wdat); end
        checks++; if (fwd1_dat !== 32'hB) begin failures++; $display("[TB] FAIL fwd_during_drain got=%h exp=b", fwd1_dat); end
        cycle();
        checks++; if (wdat !== 32'hB) begin failures++; $display("[TB] FAIL order_second got=%h exp=b", wdat); end
        checks++; if (fwd1_hit !== 1'b1) begin failures++; $display("[TB] FAIL fwd_head_draining got=%0b exp=1", fwd1_hit); end
        checks++; if (fwd1_dat !== 32'hB) begin failures++; $display("[TB] FAIL fwd_head_dat got=%h exp=b", fwd1_dat); end
        cycle();
        checks++; if (fwd1_hit !== 1'b0) begin failures++; $display("[TB] FAIL fwd_after_drain got=%0b exp=0", fwd1_hit); end
        checks++; if (WEN !== 1'b0) begin failures++; $display("[TB] FAIL fwd_idle_wen got=%0b exp=0", WEN); end
    endtask

    task automatic test_reg_zero();
        port_busy = 1'b0;
        rsel1     = 5'd0;
        enq_valid = 1'b1;
        enq_wsel  = 5'd0;
        enq_wdat  = 32'hFFFF;
        #1;
        checks++; if (enq_ready !== 1'b1) begin failures++; $display("[TB] FAIL r0_ready got=%0b exp=1", enq_ready); end
        checks++; if (fwd1_hit !== 1'b0) begin failures++; $display("[TB] FAIL r0_fwd got=%0b exp=0", fwd1_hit); end
        cycle();
        enq_valid = 1'b0;
        #1;
        checks++; if (count !== 3'd0) begin failures++; $display("[TB] FAIL r0_count got=%0d exp=0", count); end
        checks++; if (WEN !== 1'b0) begin failures++; $display("[TB] FAIL r0_wen got=%0b exp=0", WEN); end
    endtask

    task automatic test_reset_midop();
        port_busy = 1'b1;
        rsel2     = 5'd9;
        push(5'd8, 32'h80);
        push(5'd9, 32'h90);
        push(5'd10, 32'hA0);
        #1;
        checks++; if (count !== 3'd3) begin failures++; $display("[TB] FAIL midrst_count3 got=%0d exp=3", count); end
        checks++; if (fwd2_dat !== 32'h90) begin failures++; $display("[TB] FAIL midrst_fwd_before got=%h exp=90", fwd2_dat); end
        #2;
        port_busy = 1'b0;
        nRST      = 1'b0;
        #1;
        checks++; if (count !== 3'd0) begin failures++; $display("[TB] FAIL midrst_count0 got=%0d exp=0", count); end
        checks++; if (WEN !== 1'b0) begin failures++; $display("[TB] FAIL midrst_wen got=%0b exp=0", WEN); end
        checks++; if (fwd2_hit !== 1'b0) begin failures++; $display("[TB] FAIL midrst_fwd got=%0b exp=0", fwd2_hit); end
        #3;
        nRST = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++; if (WEN !== 1'b0) begin failures++; $display("[TB] FAIL midrst_after_wen[%0d] got=%0b exp=0", i, WEN); end
        end
        checks++; if (count !== 3'd0) begin failures++; $display("[TB] FAIL midrst_after_count got=%0d exp=0", count); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single();
        test_busy_fill();
        test_full_pushpop();
        test_forward_same_reg();
        test_reg_zero();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

endmodule
